padovan_seq_ctrl: RTL and testbench

Handshake-driven sequencer for the shared 8-entry register-file/ALU datapath that generates Padovan terms P(n)=P(n-2)+P(n-3). It drives the read-port decoders (A, B), the write decoder (C) and the ALU operation select. On each `start` it seeds R0..R2 from program register R6 and runs a programmable number of add/shift iterations. Each new term is announced with a strobe and index. The block replaces free-running sequencing with a start/busy/done interface and an optional overflow abort.

---
 rtl/padovan_pkg.sv | 64 ++++++
 rtl/padovan_term_cnt.sv | 36 +++
 rtl/padovan_seq_ctrl.sv | 103 ++++++++++
 tb/tb_padovan_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/padovan_pkg.sv
// rtl/padovan_pkg.sv - state encoding, opcodes, register indices and per-state control word
package padovan_pkg;

  localparam int SEL_W = 3;
  localparam int ALU_W = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LD0  = 4'd1,
    S_LD1  = 4'd2,
    S_LD2  = 4'd3,
    S_ADD  = 4'd4,
    S_MV0  = 4'd5,
    S_MV1  = 4'd6,
    S_MV2  = 4'd7,
    S_DONE = 4'd8,
    S_ERR  = 4'd9
  } state_t;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b010;

  localparam logic [SEL_W-1:0] R0    = 3'b000;
  localparam logic [SEL_W-1:0] R1    = 3'b001;
  localparam logic [SEL_W-1:0] R2    = 3'b010;
  localparam logic [SEL_W-1:0] R3    = 3'b011;
  localparam logic [SEL_W-1:0] R4    = 3'b100;
  localparam logic [SEL_W-1:0] RP1   = 3'b101;
  localparam logic [SEL_W-1:0] RP0   = 3'b110;
  localparam logic [SEL_W-1:0] RNONE = 3'b111;

  typedef struct packed {
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_c;
    logic [ALU_W-1:0] alu;
    logic             busy;
    logic             done;
    logic             term_valid;
  } ctl_t;

  // Datapath control word presented while the FSM sits in state s.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '{sel_a: R0, sel_b: R0, sel_c: RNONE, alu: ALU_PASS,
          busy: 1'b1, done: 1'b0, term_valid: 1'b0};
    case (s)
      S_IDLE: c.busy = 1'b0;
      S_LD0:  begin c.sel_a = RP0; c.sel_b = RNONE; c.sel_c = R0; end
      S_LD1:  begin c.sel_a = RP0; c.sel_b = RNONE; c.sel_c = R1; end
      S_LD2:  begin c.sel_a = RP0; c.sel_b = RNONE; c.sel_c = R2; end
      S_ADD:  begin c.sel_a = R0;  c.sel_b = R1;    c.sel_c = R3; c.alu = ALU_ADD; end
      S_MV0:  begin c.sel_a = R1;  c.sel_b = RNONE; c.sel_c = R0; end
      S_MV1:  begin c.sel_a = R2;  c.sel_b = RNONE; c.sel_c = R1; end
      S_MV2:  begin c.sel_a = R3;  c.sel_b = RNONE; c.sel_c = R2; c.term_valid = 1'b1; end
      S_DONE: c.done = 1'b1;
      S_ERR:  c.done = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/padovan_term_cnt.sv
// rtl/padovan_term_cnt.sv - remaining-iteration and term-index counters
module padovan_term_cnt
  import padovan_pkg::*;
#(
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [CNTW-1:0] n_load,
  output logic [CNTW-1:0] term_idx,
  output logic            zero,
  output logic            last
);

  logic [CNTW-1:0] rem_cnt;

  // Load on accepted start; count one term per completed MV2.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_cnt  <= '0;
      term_idx <= '0;
    end else if (load) begin
      rem_cnt  <= n_load;
      term_idx <= CNTW'(3);
    end else if (step) begin
      rem_cnt  <= rem_cnt - CNTW'(1);
      term_idx <= term_idx + CNTW'(1);
    end
  end

  assign zero = (rem_cnt == '0);
  assign last = (rem_cnt == CNTW'(1));

endmodule

// File: rtl/padovan_seq_ctrl.sv
// rtl/padovan_seq_ctrl.sv - Padovan sequencer FSM; PADOVAN_OVF_ABORT_EN enables carry abort
module padovan_seq_ctrl
  import padovan_pkg::*;
#(
  parameter int SELECTIONALU  = 3,
  parameter int SELECTIONDECO = 3,
  parameter int CNTW          = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNTW-1:0]          nTerms,
  input  logic                     sOverflow,
  input  logic                     sCarry,
  input  logic                     sNegative,
  input  logic                     sZero,
  output logic [SELECTIONDECO-1:0] sSelDecoA,
  output logic [SELECTIONDECO-1:0] sSelDecoB,
  output logic [SELECTIONDECO-1:0] sSelDecoC,
  output logic [SELECTIONALU-1:0]  sSelAlu,
  output logic                     busy,
  output logic                     done,
  output logic                     termValid,
  output logic [CNTW-1:0]          termIdx,
  output logic                     errOvf
);

  state_t state;
  ctl_t   ctl;
  logic   cnt_zero;
  logic   cnt_last;
  logic   accept;

  // Only the carry flag matters, and only in the abort build.
  logic unused_flags;
  assign unused_flags = ^{sOverflow, sNegative, sZero, sCarry};

  assign accept = (state == S_IDLE) && start;

  padovan_term_cnt #(.CNTW(CNTW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state == S_MV2),
    .n_load   (nTerms),
    .term_idx (termIdx),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  // Sequencer: control word is registered together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ctl   <= ctl_of(S_IDLE);
    end else begin
      case (state)
        S_IDLE: if (start) begin state <= S_LD0; ctl <= ctl_of(S_LD0); end
        S_LD0:  begin state <= S_LD1; ctl <= ctl_of(S_LD1); end
        S_LD1:  begin state <= S_LD2; ctl <= ctl_of(S_LD2); end
        S_LD2: begin
          if (cnt_zero) begin state <= S_DONE; ctl <= ctl_of(S_DONE); end
          else          begin state <= S_ADD;  ctl <= ctl_of(S_ADD);  end
        end
        S_ADD: begin
`ifdef PADOVAN_OVF_ABORT_EN
          if (sCarry) begin state <= S_ERR; ctl <= ctl_of(S_ERR); end
          else        begin state <= S_MV0; ctl <= ctl_of(S_MV0); end
`else
          state <= S_MV0;
          ctl   <= ctl_of(S_MV0);
`endif
        end
        S_MV0:  begin state <= S_MV1; ctl <= ctl_of(S_MV1); end
        S_MV1:  begin state <= S_MV2; ctl <= ctl_of(S_MV2); end
        S_MV2: begin
          if (cnt_last) begin state <= S_DONE; ctl <= ctl_of(S_DONE); end
          else          begin state <= S_ADD;  ctl <= ctl_of(S_ADD);  end
        end
        default: begin state <= S_IDLE; ctl <= ctl_of(S_IDLE); end
      endcase
    end
  end

`ifdef PADOVAN_OVF_ABORT_EN
  // Sticky abort flag: set by a carrying add, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst || accept) errOvf <= 1'b0;
    else if (state == S_ADD && sCarry) errOvf <= 1'b1;
  end
`else
  assign errOvf = 1'b0;
`endif

  assign sSelDecoA = ctl.sel_a;
  assign sSelDecoB = ctl.sel_b;
  assign sSelDecoC = ctl.sel_c;
  assign sSelAlu   = ctl.alu;
  assign busy      = ctl.busy;
  assign done      = ctl.done;
  assign termValid = ctl.term_valid;

endmodule

// File: tb/tb_padovan_seq_ctrl.sv
// tb/tb_padovan_seq_ctrl.sv - self-checking bench with 8-bit register-file/ALU model
module tb_padovan_seq_ctrl;

  localparam int CNTW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [CNTW-1:0] nTerms = '0;
  logic            sOverflow, sCarry, sNegative, sZero;
  logic [2:0]      sSelDecoA, sSelDecoB, sSelDecoC, sSelAlu;
  logic            busy, done, termValid, errOvf;
  logic [CNTW-1:0] termIdx;

  int errors = 0;
  int checks = 0;

  typedef struct { int value; int idx; } term_t;
  term_t sb[$];

  logic [7:0] rf [8];
  logic [7:0] op_a, op_b, alu_y;
  logic [8:0] sum;

  always #5 clk = ~clk;

  padovan_seq_ctrl #(.SELECTIONALU(3), .SELECTIONDECO(3), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .nTerms    (nTerms),
    .sOverflow (sOverflow),
    .sCarry    (sCarry),
    .sNegative (sNegative),
    .sZero     (sZero),
    .sSelDecoA (sSelDecoA),
    .sSelDecoB (sSelDecoB),
    .sSelDecoC (sSelDecoC),
    .sSelAlu   (sSelAlu),
    .busy      (busy),
    .done      (done),
    .termValid (termValid),
    .termIdx   (termIdx),
    .errOvf    (errOvf)
  );

  // Shared datapath: read ports, ALU and flags.
  always_comb begin
    op_a = rf[sSelDecoA];
    op_b = rf[sSelDecoB];
    sum  = {1'b0, op_a} + {1'b0, op_b};
    case (sSelAlu)
      3'b001:  alu_y = op_a - op_b;
      3'b010:  alu_y = sum[7:0];
      default: alu_y = op_a;
    endcase
    sCarry    = (sSelAlu == 3'b010) && sum[8];
    sOverflow = (op_a[7] == op_b[7]) && (sum[7] != op_a[7]);
    sNegative = alu_y[7];
    sZero     = (alu_y == 8'd0);
  end

  // Register file write port; R6 holds the seed.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= (i == 6) ? 8'd1 : 8'd0;
    end else if (sSelDecoC != 3'b111) begin
      rf[sSelDecoC] <= alu_y;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle and score any announced term.
  task automatic tick();
    term_t e;
    @(negedge clk);
    if (termValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_term_valid", termValid, 0);
      end else begin
        e = sb.pop_front();
        check("term_value", alu_y, e.value);
        check("term_idx", termIdx, e.idx);
      end
    end
  endtask

  task automatic run(input int n, input int n_push, input int exp_lat,
                     input bit exp_err, input int poke_at);
    int p [0:63];
    int lat;
    term_t e;
    p[0] = 1; p[1] = 1; p[2] = 1;
    for (int i = 3; i < 64; i++) p[i] = p[i-2] + p[i-3];
    for (int i = 0; i < n_push; i++) begin
      e.value = p[3+i] % 256;
      e.idx   = (3 + i) % 64;
      sb.push_back(e);
    end
    start  = 1'b1;
    nTerms = CNTW'(n);
    tick();
    start  = 1'b0;
    nTerms = '1;
    lat = 1;
    check("busy_after_start", busy, 1);
    check("errovf_cleared_on_start", errOvf, 0);
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (lat == poke_at) begin
        check("alu_add_at_poke", sSelAlu, 3'b010);
        start  = 1'b1;
        nTerms = '0;
      end else if (lat == poke_at + 1) begin
        start = 1'b0;
      end
    end
    check("done_latency", lat, exp_lat);
    check("errovf_at_done", errOvf, exp_err);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("errovf_sticky", errOvf, exp_err);
  endtask

  initial begin
    bit seen_done;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_term_valid", termValid, 0);
    check("rst_errovf", errOvf, 0);
    check("rst_term_idx", termIdx, 0);
    check("rst_sel_a", sSelDecoA, 3'b000);
    check("rst_sel_b", sSelDecoB, 3'b000);
    check("rst_sel_c", sSelDecoC, 3'b111);
    check("rst_alu", sSelAlu, 3'b000);

    // Reset during MV1 aborts with no done.
    start  = 1'b1;
    nTerms = CNTW'(5);
    tick();
    start = 1'b0;
    for (int j = 2; j <= 6; j++) tick();
    check("mv1_sel_a", sSelDecoA, 3'b010);
    check("mv1_sel_c", sSelDecoC, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_sel_c", sSelDecoC, 3'b111);
    check("midrst_done", done, 0);
    check("midrst_term_idx", termIdx, 0);
    seen_done = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      seen_done = seen_done | (done === 1'b1);
    end
    check("midrst_no_done", seen_done, 0);

    // Normal run: five terms.
    run(5, 5, 24, 1'b0, -10);
    check("end_r0", rf[0], 3);
    check("end_r1", rf[1], 4);
    check("end_r2", rf[2], 5);
    check("end_r3", rf[3], 5);

    // Zero terms.
    run(0, 0, 4, 1'b0, -10);
    check("zero_r0", rf[0], 1);
    check("zero_r1", rf[1], 1);
    check("zero_r2", rf[2], 1);

    // Start pulsed during ADD must be ignored.
    run(3, 3, 16, 1'b0, 4);

    // Long run that overflows the 8-bit datapath at index 21.
`ifdef PADOVAN_OVF_ABORT_EN
    run(30, 18, 77, 1'b1, -10);
`else
    run(30, 30, 124, 1'b0, -10);
`endif

    // Next start clears any abort flag.
    run(0, 0, 4, 1'b0, -10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
